// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction decode stage: opcodes, immediate
// formats, instruction field positions and the ID/EX bundle layout.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int OPC_LSB  = 0;
  localparam int RD_LSB   = 7;
  localparam int F3_LSB   = 12;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;
  localparam int F7B5_POS = 30;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        reg_write;
    logic        illegal;
  } id_ex_t;

  // x0 wins, then a write landing this cycle, then a write that raced the bank read.
  function automatic logic [31:0] pick_operand(
    input logic [4:0]  rs,
    input logic        fwd_en,
    input logic        wb_we,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_data,
    input logic        s1_fwd,
    input logic [31:0] s1_fwdd,
    input logic [31:0] br_rd
  );
    logic [31:0] val;
    if (rs == 5'd0)                                val = '0;
    else if (fwd_en && wb_we && (wb_addr == rs))   val = wb_data;
    else if (fwd_en && s1_fwd)                     val = s1_fwdd;
    else                                           val = br_rd;
    return val;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of the decode stage's fetch, bank, writeback and execute-side signals.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  br_a1;
  logic [4:0]  br_a2;
  logic [31:0] br_rd1;
  logic [31:0] br_rd2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_reg_write;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, br_rd1, br_rd2, wb_we, wb_addr, wb_data, flush, out_ready,
    output in_ready, br_a1, br_a2, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rd, out_opcode, out_funct3, out_funct7b5, out_reg_write, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, br_rd1, br_rd2, wb_we, wb_addr, wb_data, flush, out_ready,
    input  in_ready, br_a1, br_a2, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rd, out_opcode, out_funct3, out_funct7b5, out_reg_write, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator: classifies the opcode, builds the sign-extended
// immediate and flags writes to rd and unsupported opcodes.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output logic        reg_write_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  imm_type_e  imm_type;

  assign opcode = instr_i[OPC_LSB +: 7];

  always_comb begin
    imm_type    = IMM_NONE;
    reg_write_o = 1'b0;
    illegal_o   = 1'b0;
    case (opcode)
      OPC_OP:                       reg_write_o = 1'b1;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm_type    = IMM_I;
        reg_write_o = 1'b1;
      end
      OPC_STORE:                    imm_type = IMM_S;
      OPC_BRANCH:                   imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC: begin
        imm_type    = IMM_U;
        reg_write_o = 1'b1;
      end
      OPC_JAL: begin
        imm_type    = IMM_J;
        reg_write_o = 1'b1;
      end
      default:                      illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (imm_type)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Two-register decode stage: S1 holds the instruction while the bank read completes,
// S2 is the registered ID/EX bundle presented downstream.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int FWD_EN = 1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_instr_q, s1_instr_d;
  logic [31:0] s1_pc_q,    s1_pc_d;
  logic        out_valid_q, out_valid_d;
  id_ex_t      out_q, out_d, bundle;

  logic        adv1, adv2, in_ready, load1;
  logic [4:0]  br_a   [2];
  logic [31:0] br_rd  [2];
  logic [XLEN-1:0] op_val [2];

  logic [31:0] imm;
  logic        reg_write, illegal;

  assign adv2     = !out_valid_q | bus.out_ready;
  assign adv1     = s1_valid_q & adv2;
  assign in_ready = !s1_valid_q | adv1;
  assign load1    = bus.in_valid & in_ready & !bus.flush;

  assign br_rd[0] = bus.br_rd1;
  assign br_rd[1] = bus.br_rd2;

  // Addresses follow the instruction being loaded so the bank's registered read lines
  // up with S1; while S1 holds, the bank keeps re-reading the held addresses.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      localparam int LSB = (gi == 0) ? RS1_LSB : RS2_LSB;
      logic        fwd_q, fwd_d;
      logic [31:0] fwdd_q;

      assign br_a[gi] = load1 ? bus.in_instr[LSB +: 5] : s1_instr_q[LSB +: 5];
      assign fwd_d    = bus.wb_we & (bus.wb_addr == br_a[gi]) & (br_a[gi] != 5'd0);

      always_ff @(posedge clk) begin
        if (rst) begin
          fwd_q  <= 1'b0;
          fwdd_q <= '0;
        end else begin
          fwd_q  <= fwd_d;
          fwdd_q <= bus.wb_data;
        end
      end

      assign op_val[gi] = pick_operand(s1_instr_q[LSB +: 5], FWD_EN != 0, bus.wb_we,
                                       bus.wb_addr, bus.wb_data, fwd_q, fwdd_q, br_rd[gi]);
    end
  endgenerate

  assign bus.br_a1 = br_a[0];
  assign bus.br_a2 = br_a[1];

  imm_gen u_imm_gen (
    .instr_i     (s1_instr_q),
    .imm_o       (imm),
    .reg_write_o (reg_write),
    .illegal_o   (illegal)
  );

  always_comb begin
    bundle           = '0;
    bundle.pc        = s1_pc_q;
    bundle.rs1_val   = op_val[0];
    bundle.rs2_val   = op_val[1];
    bundle.imm       = imm;
    bundle.rd        = reg_write ? s1_instr_q[RD_LSB +: 5] : 5'd0;
    bundle.opcode    = s1_instr_q[OPC_LSB +: 7];
    bundle.funct3    = s1_instr_q[F3_LSB +: 3];
    bundle.funct7b5  = s1_instr_q[F7B5_POS];
    bundle.reg_write = reg_write;
    bundle.illegal   = illegal;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_instr_d  = s1_instr_q;
    s1_pc_d     = s1_pc_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (bus.flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (load1) begin
        s1_valid_d = 1'b1;
        s1_instr_d = bus.in_instr;
        s1_pc_d    = bus.in_pc;
      end else if (adv1) begin
        s1_valid_d = 1'b0;
      end
      if (adv2) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) out_d = bundle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_instr_q  <= '0;
      s1_pc_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_instr_q  <= s1_instr_d;
      s1_pc_q     <= s1_pc_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_q.pc;
  assign bus.out_rs1_val   = out_q.rs1_val;
  assign bus.out_rs2_val   = out_q.rs2_val;
  assign bus.out_imm       = out_q.imm;
  assign bus.out_rd        = out_q.rd;
  assign bus.out_opcode    = out_q.opcode;
  assign bus.out_funct3    = out_q.funct3;
  assign bus.out_funct7b5  = out_q.funct7b5;
  assign bus.out_reg_write = out_q.reg_write;
  assign bus.out_illegal   = out_q.illegal;

endmodule
